// File: rtl/edge_sync_filter_if.sv
// Signal bundle for edge_sync_filter: async inputs, per-channel reset level
// and clear in one direction; synchronised level, edge pulses and sticky flags in the other.
interface edge_sync_filter_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] phase;
  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] clear;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] riseSeen;
  logic [WIDTH-1:0] fallSeen;

  modport master (
    output phase, in, clear,
    input  out, rise, fall, riseSeen, fallSeen
  );

  modport slave (
    input  phase, in, clear,
    output out, rise, fall, riseSeen, fallSeen
  );
endinterface

// File: rtl/edge_sync_filter.sv
// Multi-channel async-input synchroniser with optional per-channel deglitch filter.
// Ports: clk, nReset (async low), bus (slave: phase/in/clear in; out/rise/fall/riseSeen/fallSeen out).
module edge_sync_filter #(
  parameter int WIDTH         = 1,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 0
) (
  input logic             clk,
  input logic             nReset,
  edge_sync_filter_if.slave bus
);

  logic [WIDTH-1:0] out_v;
  logic [WIDTH-1:0] cmp_v;
  logic [WIDTH-1:0] rise_v;
  logic [WIDTH-1:0] fall_v;
  logic [WIDTH-1:0] rs_v;
  logic [WIDTH-1:0] fs_v;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] s;

    // Sync flops load the channel's idle level so release is pulse-free.
    always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
        s <= {SYNC_STAGES{bus.phase[i]}};
      end else begin
        s <= {s[SYNC_STAGES-2:0], bus.in[i]};
      end
    end

    if (FILTER_CYCLES == 0) begin : g_nf
      assign out_v[i] = s[SYNC_STAGES-1];
    end else begin : g_f
      localparam int CW = (FILTER_CYCLES > 1) ?
                          $clog2(FILTER_CYCLES) : 1;
      localparam logic [CW-1:0] CMAX = CW'(FILTER_CYCLES - 1);

      logic [CW-1:0] cnt;
      logic          q;

      // Any sample agreeing with q restarts the count,
      // so glitches never accumulate.
      always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
          q   <= bus.phase[i];
          cnt <= '0;
        end else if (s[SYNC_STAGES-1] == q) begin
          cnt <= '0;
        end else if (cnt == CMAX) begin
          q   <= s[SYNC_STAGES-1];
          cnt <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end

      assign out_v[i] = q;
    end

    always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
        cmp_v[i] <= bus.phase[i];
        rs_v[i]  <= 1'b0;
        fs_v[i]  <= 1'b0;
      end else begin
        cmp_v[i] <= out_v[i];
        rs_v[i]  <= rise_v[i] | (rs_v[i] & ~bus.clear[i]);
        fs_v[i]  <= fall_v[i] | (fs_v[i] & ~bus.clear[i]);
      end
    end
  end

  assign rise_v       = out_v & ~cmp_v;
  assign fall_v       = ~out_v & cmp_v;
  assign bus.out      = out_v;
  assign bus.rise     = rise_v;
  assign bus.fall     = fall_v;
  assign bus.riseSeen = rs_v;
  assign bus.fallSeen = fs_v;

endmodule

// File: tb/tb_edge_sync_filter.sv
// Directed testbench for edge_sync_filter over three parameter sets.
// Ports exercised: clk, nReset, and every bus signal of each instance.
module tb_edge_sync_filter;

  logic clk = 1'b0;
  logic rn0 = 1'b1;
  logic rn1 = 1'b1;
  logic rn2 = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  edge_sync_filter_if #(.WIDTH(1)) b0 ();
  edge_sync_filter_if #(.WIDTH(4)) b1 ();
  edge_sync_filter_if #(.WIDTH(2)) b2 ();

  edge_sync_filter #(
    .WIDTH(1), .SYNC_STAGES(2), .FILTER_CYCLES(0)
  ) u0 (.clk(clk), .nReset(rn0), .bus(b0.slave));

  edge_sync_filter #(
    .WIDTH(4), .SYNC_STAGES(3), .FILTER_CYCLES(4)
  ) u1 (.clk(clk), .nReset(rn1), .bus(b1.slave));

  edge_sync_filter #(
    .WIDTH(2), .SYNC_STAGES(4), .FILTER_CYCLES(1)
  ) u2 (.clk(clk), .nReset(rn2), .bus(b2.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    b0.phase = 1'b1;  b0.in = 1'b1;  b0.clear = 1'b0;
    b1.phase = 4'h0;  b1.in = 4'h0;  b1.clear = 4'h0;
    b2.phase = 2'b00; b2.in = 2'b00; b2.clear = 2'b00;
    #1;
    rn0 = 1'b0; rn1 = 1'b0; rn2 = 1'b0;
    #1;
    checks++;
    if (b0.out !== 1'b1) begin
      errors++;
      $display("FAIL reset_out0: got %b want 1", b0.out);
    end
    checks++;
    if ({b0.rise, b0.fall, b0.riseSeen, b0.fallSeen} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags0: got %b want 0000",
               {b0.rise, b0.fall, b0.riseSeen, b0.fallSeen});
    end
    checks++;
    if ({b1.out, b1.rise, b1.fall} !== 12'h0) begin
      errors++;
      $display("FAIL reset_dut1: got %h want 000",
               {b1.out, b1.rise, b1.fall});
    end
    tick(); tick();
    rn0 = 1'b1; rn1 = 1'b1; rn2 = 1'b1;
    tick(); tick();
    checks++;
    if ({b0.out, b0.rise, b0.fall} !== 3'b100) begin
      errors++;
      $display("FAIL reset_release0: got %b want 100",
               {b0.out, b0.rise, b0.fall});
    end
    checks++;
    if ({b2.out, b2.rise, b2.fall} !== 6'b0) begin
      errors++;
      $display("FAIL reset_release2: got %b want 000000",
               {b2.out, b2.rise, b2.fall});
    end
  endtask

  task automatic test_sync_latency();
    b0.in = 1'b0;
    tick();
    checks++;
    if ({b0.out, b0.fall} !== 2'b10) begin
      errors++;
      $display("FAIL lat_c1: got out/fall %b want 10",
               {b0.out, b0.fall});
    end
    tick();
    checks++;
    if ({b0.out, b0.rise, b0.fall} !== 3'b001) begin
      errors++;
      $display("FAIL lat_c2: got out/rise/fall %b want 001",
               {b0.out, b0.rise, b0.fall});
    end
    tick();
    checks++;
    if ({b0.out, b0.fall, b0.fallSeen} !== 3'b001) begin
      errors++;
      $display("FAIL lat_c3: got out/fall/fseen %b want 001",
               {b0.out, b0.fall, b0.fallSeen});
    end
  endtask

  task automatic test_sticky();
    b0.in = 1'b1;
    tick(); tick();
    checks++;
    if ({b0.rise, b0.riseSeen} !== 2'b10) begin
      errors++;
      $display("FAIL sticky_pulse: got rise/rseen %b want 10",
               {b0.rise, b0.riseSeen});
    end
    b0.clear = 1'b1;
    tick();
    checks++;
    if ({b0.rise, b0.riseSeen, b0.fallSeen} !== 3'b010) begin
      errors++;
      $display("FAIL sticky_setwins: got rise/rseen/fseen %b want 010",
               {b0.rise, b0.riseSeen, b0.fallSeen});
    end
    tick();
    checks++;
    if (b0.riseSeen !== 1'b0) begin
      errors++;
      $display("FAIL sticky_clear: got %b want 0", b0.riseSeen);
    end
    b0.clear = 1'b0;
    tick();
    checks++;
    if ({b0.riseSeen, b0.fallSeen} !== 2'b00) begin
      errors++;
      $display("FAIL sticky_hold: got %b want 00",
               {b0.riseSeen, b0.fallSeen});
    end
  endtask

  task automatic test_filter_pulse();
    logic [3:0] wo, wr, wf;
    b1.in = 4'b0100;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 3) b1.in = 4'b0000;
      checks++;
      if ({b1.out, b1.rise, b1.fall} !== 12'h0) begin
        errors++;
        $display("FAIL short_pulse k=%0d: got %h want 000",
                 k, {b1.out, b1.rise, b1.fall});
      end
    end
    b1.in = 4'b0100;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 4) b1.in = 4'b0000;
      wo = (k >= 7 && k <= 10) ? 4'b0100 : 4'b0000;
      wr = (k == 7)  ? 4'b0100 : 4'b0000;
      wf = (k == 11) ? 4'b0100 : 4'b0000;
      checks++;
      if ({b1.out, b1.rise, b1.fall} !== {wo, wr, wf}) begin
        errors++;
        $display("FAIL long_pulse k=%0d: got %h want %h",
                 k, {b1.out, b1.rise, b1.fall}, {wo, wr, wf});
      end
    end
  endtask

  task automatic test_glitch_train();
    for (int k = 0; k < 40; k++) begin
      b1.in[0] = (k < 32) && (k % 4 != 3);
      tick();
      checks++;
      if ({b1.out[0], b1.rise[0], b1.fall[0]} !== 3'b000) begin
        errors++;
        $display("FAIL glitch k=%0d: got out/rise/fall %b want 000",
                 k, {b1.out[0], b1.rise[0], b1.fall[0]});
      end
    end
  endtask

  task automatic test_phase_reset();
    logic [3:0] wo, wr;
    rn1 = 1'b0;
    b1.phase = 4'b1010;
    b1.in = 4'b1010;
    #1;
    checks++;
    if ({b1.out, b1.rise, b1.fall} !== 12'hA00) begin
      errors++;
      $display("FAIL phase_async: got %h want a00",
               {b1.out, b1.rise, b1.fall});
    end
    tick();
    rn1 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (k == 2) b1.phase = 4'b0101;
      checks++;
      if ({b1.out, b1.rise, b1.fall} !== 12'hA00) begin
        errors++;
        $display("FAIL phase_release k=%0d: got %h want a00",
                 k, {b1.out, b1.rise, b1.fall});
      end
    end
    b1.phase = 4'b1010;
    b1.in = 4'b1011;
    for (int k = 0; k < 5; k++) tick();
    rn1 = 1'b0;
    #1;
    checks++;
    if ({b1.out, b1.rise, b1.fall} !== 12'hA00) begin
      errors++;
      $display("FAIL midfilter_reset: got %h want a00",
               {b1.out, b1.rise, b1.fall});
    end
    b1.in = 4'b1010;
    tick();
    rn1 = 1'b1;
    tick(); tick();
    b1.in = 4'b1011;
    for (int k = 1; k <= 9; k++) begin
      tick();
      wo = (k >= 7) ? 4'b1011 : 4'b1010;
      wr = (k == 7) ? 4'b0001 : 4'b0000;
      checks++;
      if ({b1.out, b1.rise, b1.fall} !== {wo, wr, 4'b0000}) begin
        errors++;
        $display("FAIL relatch k=%0d: got %h want %h",
                 k, {b1.out, b1.rise, b1.fall}, {wo, wr, 4'b0000});
      end
    end
  endtask

  task automatic test_f1_random();
    logic [1:0] hist[$];
    logic [1:0] exp_v, prev_v, v;
    int         n, mr, mf, dr, df;
    prev_v = 2'b00;
    mr = 0; mf = 0; dr = 0; df = 0;
    for (int k = 0; k < 200; k++) begin
      #($urandom_range(0, 7));
      v = 2'($urandom);
      b2.in = v;
      hist.push_back(v);
      tick();
      n = hist.size();
      exp_v = (n >= 5) ? hist[n-5] : 2'b00;
      for (int b = 0; b < 2; b++) begin
        if (exp_v[b] && !prev_v[b]) mr++;
        if (!exp_v[b] && prev_v[b]) mf++;
        if (b2.rise[b]) dr++;
        if (b2.fall[b]) df++;
      end
      prev_v = exp_v;
      checks++;
      if (b2.out !== exp_v) begin
        errors++;
        $display("FAIL rand_out k=%0d: got %b want %b",
                 k, b2.out, exp_v);
      end
      checks++;
      if ((b2.rise & b2.fall) !== 2'b00) begin
        errors++;
        $display("FAIL rand_both k=%0d: got %b want 00",
                 k, b2.rise & b2.fall);
      end
    end
    checks++;
    if (dr != mr) begin
      errors++;
      $display("FAIL rand_rise_count: got %0d want %0d", dr, mr);
    end
    checks++;
    if (df != mf) begin
      errors++;
      $display("FAIL rand_fall_count: got %0d want %0d", df, mf);
    end
  endtask

  initial begin
    test_reset();
    test_sync_latency();
    test_sticky();
    test_filter_pulse();
    test_glitch_train();
    test_phase_reset();
    test_f1_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
